// File: rtl/reader_controller_if.sv
// Reader/parser bus bundle for reader_controller.
//
// Groups the two handshakes the controller sits between:
//   - char-stream reader : rd_state_enable, rd_argument, rd_pause (to reader),
//                          rd_has_finished, rd_char (from reader)
//   - HTML parser        : out_char, out_valid (to parser), out_ready (from parser)
//
// Modports:
//   master - the controller side
//   slave  - the reader/parser side
interface reader_controller_if #(
   parameter int unsigned CHAR_W = 8
);

   logic              rd_state_enable;
   logic [7:0]        rd_argument;
   logic              rd_pause;
   logic              rd_has_finished;
   logic [CHAR_W-1:0] rd_char;

   logic [CHAR_W-1:0] out_char;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output rd_state_enable,
      output rd_argument,
      output rd_pause,
      input  rd_has_finished,
      input  rd_char,
      output out_char,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  rd_state_enable,
      input  rd_argument,
      input  rd_pause,
      output rd_has_finished,
      output rd_char,
      input  out_char,
      input  out_valid,
      output out_ready
   );

endinterface

// File: rtl/reader_controller.sv
// Char-stream reader controller.
//
// Sequences one char-stream reader (enable, page argument, pause throttling,
// end-of-stream detection), buffers the received chars in a small
// first-word-fall-through FIFO and hands them to the HTML parser over a
// valid/ready handshake. Status goes back to the browser FSM.
//
// Ports:
//   clock, resetn      - clock (rising edge), asynchronous active-low reset
//   start, page_sel    - begin a page fetch (IDLE only); page id latched on accept
//   abort              - cancel the stream and flush the buffer
//   busy               - high in RUN and DRAIN
//   done               - one-cycle pulse on normal or truncated completion
//   error_truncated    - MAX_CHARS reached before end of stream (sticky until next start)
//   char_count         - chars written to the buffer for the current stream
//   bus                - reader and parser handshakes (see reader_controller_if)
module reader_controller #(
   parameter int unsigned CHAR_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_CHARS  = 4096,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [7:0]       page_sel,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             error_truncated,
   output logic [CNT_W-1:0] char_count,
   reader_controller_if.master bus
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] MaxCount   = CNT_W'(MAX_CHARS);
   localparam logic [CNT_W-1:0] MaxCountM1 = CNT_W'(MAX_CHARS - 1);
   localparam logic [OCC_W:0]   DepthExt   = (OCC_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic              fetch_pending_q, fetch_pending_d;
   logic [7:0]        arg_q, arg_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              trunc_q, trunc_d;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [CHAR_W-1:0] mem_q [FIFO_DEPTH];

   // ------------------------------------------------------------------------
   // Datapath decode
   // ------------------------------------------------------------------------
   logic             fifo_empty;
   logic             pop;
   logic             push;
   logic             valid_fetch;
   logic             is_nul;
   logic             pause;
   logic [OCC_W:0]   occ_pend;
   logic [OCC_W-1:0] occ_after_pop;

   always_comb begin
      fifo_empty    = (occ_q == '0);
      pop           = ~fifo_empty & bus.out_ready;
      // A fetch issued last cycle only counts if the reader did not flag the
      // end of stream alongside it; that char is stale.
      valid_fetch   = (state_q == StRun) & fetch_pending_q & ~bus.rd_has_finished;
      is_nul        = (bus.rd_char == '0);
      push          = valid_fetch & ~is_nul & ~abort;
      // Reserve a slot for the fetch already in flight so the FIFO cannot overflow.
      occ_pend      = {1'b0, occ_q} + (OCC_W + 1)'(fetch_pending_q);
      pause         = ~((state_q == StRun) && (occ_pend < DepthExt));
      occ_after_pop = occ_q - OCC_W'(pop);
   end

   // ------------------------------------------------------------------------
   // Next-state / control
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      arg_d   = arg_q;
      count_d = count_q;
      trunc_d = trunc_q;
      done    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d = StRun;
               arg_d   = page_sel;
               count_d = '0;
               trunc_d = 1'b0;
            end
         end

         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (valid_fetch) begin
               if (is_nul) begin
                  state_d = StDrain;
               end else begin
                  if (count_q < MaxCount) begin
                     count_d = count_q + CNT_W'(1);
                  end
                  if (count_q == MaxCountM1) begin
                     state_d = StDrain;
                     trunc_d = 1'b1;
                  end
               end
            end else if (bus.rd_has_finished) begin
               state_d = StDrain;
            end
         end

         StDrain: begin
            if (abort) begin
               state_d = StIdle;
            end else if (occ_after_pop == '0) begin
               state_d = StDone;
            end
         end

         StDone: begin
            state_d = StIdle;
            done    = ~abort;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // The reader fetches on an edge where it is enabled, unpaused and not
      // finished. Anything fetched as we leave RUN is dropped.
      fetch_pending_d = (state_q == StRun) && (state_d == StRun) &&
                        !pause && !bus.rd_has_finished;
   end

   // ------------------------------------------------------------------------
   // FIFO pointer / occupancy update
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;

      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q         <= StIdle;
         fetch_pending_q <= 1'b0;
         arg_q           <= '0;
         count_q         <= '0;
         trunc_q         <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         occ_q           <= '0;
      end else begin
         state_q         <= state_d;
         fetch_pending_q <= fetch_pending_d;
         arg_q           <= arg_d;
         count_q         <= count_d;
         trunc_q         <= trunc_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         occ_q           <= occ_d;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= bus.rd_char;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      busy                = (state_q == StRun) || (state_q == StDrain);
      error_truncated     = trunc_q;
      char_count          = count_q;
      bus.rd_state_enable = (state_q == StRun);
      bus.rd_argument     = arg_q;
      bus.rd_pause        = pause;
      bus.out_valid       = ~fifo_empty;
      // Head is forced to zero when empty so flushed entries never show.
      bus.out_char        = fifo_empty ? '0 : mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_reader_controller.sv
// Self-checking bench for reader_controller: table of page streams plus
// hand-written abort and reset sequences. Unit 0 uses default parameters,
// unit 1 uses MAX_CHARS=8 for the truncation cases.
module tb_reader_controller;

   localparam int NU = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       resetn;
   logic       start_s [NU];
   logic       abort_s [NU];
   logic [7:0] page_sel;
   logic       out_ready;

   logic       busy_w  [NU];
   logic       done_w  [NU];
   logic       trunc_w [NU];
   logic [15:0] cnt_w  [NU];
   logic       en_w    [NU];
   logic       pause_w [NU];
   logic       ov_w    [NU];
   logic [7:0] arg_w   [NU];
   logic [7:0] oc_w    [NU];

   logic [7:0] stream_mem [NU][64];
   int         fin_at [NU];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < NU; g++) begin : g_unit
      reader_controller_if #(.CHAR_W(8)) bus ();

      logic [7:0] m_char;
      int         m_idx;
      logic       m_fin;

      reader_controller #(
         .CHAR_W    (8),
         .FIFO_DEPTH(4),
         .MAX_CHARS ((g == 0) ? 4096 : 8),
         .CNT_W     (16)
      ) u_dut (
         .clock          (clock),
         .resetn         (resetn),
         .start          (start_s[g]),
         .page_sel       (page_sel),
         .abort          (abort_s[g]),
         .busy           (busy_w[g]),
         .done           (done_w[g]),
         .error_truncated(trunc_w[g]),
         .char_count     (cnt_w[g]),
         .bus            (bus)
      );

      assign bus.rd_has_finished = m_fin;
      assign bus.rd_char         = m_char;
      assign bus.out_ready       = out_ready;
      assign en_w[g]             = bus.rd_state_enable;
      assign pause_w[g]          = bus.rd_pause;
      assign ov_w[g]             = bus.out_valid;
      assign arg_w[g]            = bus.rd_argument;
      assign oc_w[g]             = bus.out_char;

      // Reader model: registered char, fetch on enabled/unpaused/unfinished
      // edges. On the fetch numbered fin_at it raises has_finished and
      // presents a stale garbage char instead.
      always @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            m_idx  <= 0;
            m_fin  <= 1'b0;
            m_char <= 8'h00;
         end else if (!bus.rd_state_enable) begin
            m_idx <= 0;
            m_fin <= 1'b0;
         end else if (!bus.rd_pause && !m_fin) begin
            if (fin_at[g] != 0 && m_idx == fin_at[g]) begin
               m_fin  <= 1'b1;
               m_char <= 8'hEE;
            end else begin
               m_char <= stream_mem[g][m_idx];
               if (m_idx < 63) m_idx <= m_idx + 1;
            end
         end
      end
   end

   // Output collector for the unit under test
   int         cur_u = 0;
   logic [7:0] got [$];
   int         done_seen = 0;

   always @(negedge clock) begin
      if (resetn) begin
         if (ov_w[cur_u] && out_ready) got.push_back(oc_w[cur_u]);
         if (done_w[cur_u]) done_seen++;
      end
   end

   typedef struct {
      int    unit;
      string stream;
      int    fin;
      int    stall;
      string exp;
      int    exp_cnt;
      bit    exp_trunc;
   } vec_t;

   function automatic vec_t mk(int u, string s, int f, int st, string e, int c, bit t);
      vec_t v;
      v.unit = u; v.stream = s; v.fin = f; v.stall = st;
      v.exp = e; v.exp_cnt = c; v.exp_trunc = t;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_stream(input int u, input string s, input int f);
      for (int i = 0; i < 64; i++) stream_mem[u][i] = 8'h00;
      for (int i = 0; i < s.len() && i < 63; i++) stream_mem[u][i] = s[i];
      fin_at[u] = f;
   endtask

   task automatic check_reset_vals(input int u);
      check("rst_busy",  32'(busy_w[u]),  0);
      check("rst_done",  32'(done_w[u]),  0);
      check("rst_trunc", 32'(trunc_w[u]), 0);
      check("rst_count", 32'(cnt_w[u]),   0);
      check("rst_en",    32'(en_w[u]),    0);
      check("rst_arg",   32'(arg_w[u]),   0);
      check("rst_pause", 32'(pause_w[u]), 1);
      check("rst_valid", 32'(ov_w[u]),    0);
      check("rst_char",  32'(oc_w[u]),    0);
   endtask

   // Start pulse: sampled on the next rising edge (E0); returns at E0+1.
   task automatic pulse_start(input int u, input logic [7:0] page);
      page_sel   = page;
      start_s[u] = 1'b1;
      @(posedge clock);
      #1;
      start_s[u] = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input logic [7:0] page);
      int u;
      u         = v.unit;
      cur_u     = u;
      got.delete();
      done_seen = 0;
      load_stream(u, v.stream, v.fin);
      out_ready = (v.stall == 0);
      pulse_start(u, page);
      check("start_busy",  32'(busy_w[u]),  1);
      check("start_arg",   32'(arg_w[u]),   32'(page));
      check("start_trunc", 32'(trunc_w[u]), 0);
      check("start_count", 32'(cnt_w[u]),   0);
      if (v.exp.len() > 0) begin
         @(negedge clock);
         check("lat_e0_valid", 32'(ov_w[u]), 0);
         @(negedge clock);
         check("lat_e1_valid", 32'(ov_w[u]), 0);
         @(negedge clock);
         check("lat_e2_valid", 32'(ov_w[u]), 1);
      end
      if (v.stall > 0) begin
         repeat (v.stall) @(posedge clock);
         #1;
         check("stall_pause", 32'(pause_w[u]), 1);
         check("stall_valid", 32'(ov_w[u]),    1);
         check("stall_count", 32'(cnt_w[u]),   4);
         out_ready = 1'b1;
      end
      for (int k = 0; k < 400 && done_seen == 0; k++) @(posedge clock);
      repeat (4) @(posedge clock);
      #1;
      check("done_once", 32'(done_seen), 1);
      check("out_len", 32'(got.size()), 32'(v.exp.len()));
      for (int k = 0; k < v.exp.len() && k < got.size(); k++) begin
         check("out_char", 32'(got[k]), 32'(v.exp[k]));
      end
      check("end_count", 32'(cnt_w[u]),   32'(v.exp_cnt));
      check("end_trunc", 32'(trunc_w[u]), 32'(v.exp_trunc));
      check("end_busy",  32'(busy_w[u]),  0);
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = mk(0, "<p>hi</p>", 0, 0,  "<p>hi</p>", 9, 1'b0);
      vecs[1] = mk(0, "<p>hi</p>", 0, 20, "<p>hi</p>", 9, 1'b0);
      vecs[2] = mk(0, "abcdefgh",  5, 0,  "abcde",     5, 1'b0);
      vecs[3] = mk(0, "",          0, 0,  "",          0, 1'b0);
      vecs[4] = mk(1, "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ",
                   0, 0, "abcdefgh", 8, 1'b1);
      vecs[5] = mk(1, "ab",        0, 0,  "ab",        2, 1'b0);

      resetn    = 1'b1;
      out_ready = 1'b1;
      page_sel  = 8'h00;
      for (int u = 0; u < NU; u++) begin
         start_s[u] = 1'b0;
         abort_s[u] = 1'b0;
         load_stream(u, "", 0);
      end
      #2 resetn = 1'b0;
      #20;
      for (int u = 0; u < NU; u++) check_reset_vals(u);
      @(posedge clock);
      #1 resetn = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], 8'(i + 1));

      // Abort mid-RUN with three chars buffered
      cur_u     = 0;
      got.delete();
      done_seen = 0;
      load_stream(0, "abcdefgh", 0);
      out_ready = 1'b0;
      pulse_start(0, 8'd3);
      repeat (4) @(posedge clock);
      #1;
      check("abort_pre_count", 32'(cnt_w[0]), 3);
      check("abort_pre_valid", 32'(ov_w[0]),  1);
      abort_s[0] = 1'b1;
      @(posedge clock);
      #1;
      abort_s[0] = 1'b0;
      check("abort_busy",  32'(busy_w[0]),  0);
      check("abort_en",    32'(en_w[0]),    0);
      check("abort_valid", 32'(ov_w[0]),    0);
      check("abort_pause", 32'(pause_w[0]), 1);
      out_ready = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      check("abort_no_done", 32'(done_seen),  0);
      check("abort_no_out",  32'(got.size()), 0);

      // abort and start together in IDLE: stays IDLE
      abort_s[0] = 1'b1;
      pulse_start(0, 8'd4);
      abort_s[0] = 1'b0;
      check("abort_start_busy", 32'(busy_w[0]), 0);
      check("abort_start_en",   32'(en_w[0]),   0);

      run_vec(mk(0, "xy", 0, 0, "xy", 2, 1'b0), 8'd7);

      // Reset asserted while draining a stalled FIFO
      cur_u     = 0;
      got.delete();
      done_seen = 0;
      load_stream(0, "ab", 0);
      out_ready = 1'b0;
      pulse_start(0, 8'd9);
      repeat (6) @(posedge clock);
      #1;
      check("drain_busy",  32'(busy_w[0]), 1);
      check("drain_en",    32'(en_w[0]),   0);
      check("drain_valid", 32'(ov_w[0]),   1);
      #2 resetn = 1'b0;
      #1;
      check_reset_vals(0);
      @(posedge clock);
      #1 resetn = 1'b1;
      out_ready = 1'b1;
      run_vec(mk(0, "ok", 0, 0, "ok", 2, 1'b0), 8'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
